// File: rtl/apb4_req_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : apb4_req_master_pkg
// Brief   : Shared types and constants for the APB4 request master.
// Rev     : 1.0 - initial release
// ============================================================================
package apb4_req_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [2:0] PPROT_DEFAULT  = 3'b000;
    localparam int         RSP_DATA_WIDTH = 32;

    typedef struct packed {
        logic [RSP_DATA_WIDTH-1:0] rdata;
        logic                      slverr;
        logic                      timeout;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb4_access_timer.sv
`default_nettype none
// ============================================================================
// Module  : apb4_access_timer
// Brief   : ACCESS-phase wait-state counter; flags the TIMEOUT_CYCLES-th stall.
// Rev     : 1.0 - initial release
// ============================================================================
module apb4_access_timer
    import apb4_req_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_count;

    // expire marks the stalled cycle that would make the count reach the limit
    assign expire = tick && (r_count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (tick && !expire) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb4_req_master.sv
`default_nettype none
// ============================================================================
// Module  : apb4_req_master
// Brief   : valid/ready request channel to APB4 master with buffered response.
//           Optional ACCESS timeout enabled by APB4_REQ_MASTER_TIMEOUT_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module apb4_req_master
    import apb4_req_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    generate
        if ((DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("apb4_req_master: illegal DATA_WIDTH or TIMEOUT_CYCLES");
        end
    endgenerate

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_timeout;

    logic                    w_psel_nxt;
    logic                    w_penable_nxt;
    logic                    w_pwrite_nxt;
    logic [ADDR_WIDTH-1:0]   w_paddr_nxt;
    logic [DATA_WIDTH-1:0]   w_pwdata_nxt;
    logic [DATA_WIDTH/8-1:0] w_pstrb_nxt;
    logic                    w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   w_rsp_rdata_nxt;
    logic                    w_rsp_slverr_nxt;
    logic                    w_rsp_timeout_nxt;

`ifdef APB4_REQ_MASTER_TIMEOUT_EN
    logic w_timer_expire;

    apb4_access_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_access_timer (
        .clk    (pclk),
        .rst_n  (presetn),
        .clear  (r_state == ST_SETUP),
        .tick   ((r_state == ST_ACCESS) && !pready),
        .expire (w_timer_expire)
    );

    assign w_timeout = w_timer_expire;
`else
    assign w_timeout = 1'b0;
`endif

    // Gated by presetn so nothing is offered while reset is asserted
    assign req_ready = presetn && (r_state == ST_IDLE);
    assign pprot     = PPROT_DEFAULT;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= ST_IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            psel        <= w_psel_nxt;
            penable     <= w_penable_nxt;
            pwrite      <= w_pwrite_nxt;
            paddr       <= w_paddr_nxt;
            pwdata      <= w_pwdata_nxt;
            pstrb       <= w_pstrb_nxt;
            rsp_valid   <= w_rsp_valid_nxt;
            rsp_rdata   <= w_rsp_rdata_nxt;
            rsp_slverr  <= w_rsp_slverr_nxt;
            rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid)            w_state_nxt = ST_SETUP;
            ST_SETUP:                            w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (pready || w_timeout)  w_state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready)            w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_psel_nxt        = psel;
        w_penable_nxt     = penable;
        w_pwrite_nxt      = pwrite;
        w_paddr_nxt       = paddr;
        w_pwdata_nxt      = pwdata;
        w_pstrb_nxt       = pstrb;
        w_rsp_valid_nxt   = rsp_valid;
        w_rsp_rdata_nxt   = rsp_rdata;
        w_rsp_slverr_nxt  = rsp_slverr;
        w_rsp_timeout_nxt = rsp_timeout;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b0;
                    w_pwrite_nxt  = req_write;
                    w_paddr_nxt   = req_addr;
                    w_pwdata_nxt  = req_wdata;
                    w_pstrb_nxt   = req_write ? req_strb : '0;
                end
            end
            ST_SETUP: begin
                w_penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                // pready has priority over a timeout landing on the same edge
                if (pready || w_timeout) begin
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_pwrite_nxt      = 1'b0;
                    w_pstrb_nxt       = '0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_rdata_nxt   = (pready && !pwrite) ? prdata : '0;
                    w_rsp_slverr_nxt  = pready ? pslverr : 1'b1;
                    w_rsp_timeout_nxt = !pready;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_apb4_req_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb4_req_master
// Brief   : Directed self-checking bench with APB slave model and scoreboard.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_apb4_req_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
    } exp_t;

    logic        pclk    = 1'b0;
    logic        presetn = 1'b1;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr, rsp_timeout;
    logic        psel, penable, pwrite;
    logic [2:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata  = '0;
    logic        pready  = 1'b0;
    logic        pslverr = 1'b0;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];

    int          wait_states = 0;
    bit          slv_err     = 1'b0;
    bit          hang        = 1'b0;
    int          wcnt        = 0;
    logic [31:0] mem [2]     = '{32'h0, 32'h0};

    apb4_req_master #(
        .ADDR_WIDTH     (3),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    always #5 pclk = ~pclk;

    // Slave: drives pready half a cycle ahead of the edge that samples it
    always @(negedge pclk) begin
        if (psel && penable && !hang) begin
            if (wcnt < wait_states) begin
                pready = 1'b0;
                wcnt   = wcnt + 1;
            end else begin
                pready  = 1'b1;
                pslverr = slv_err;
                if (pwrite) begin
                    prdata = 32'h5A5A_5A5A;
                    if (!slv_err)
                        for (int b = 0; b < 4; b++)
                            if (pstrb[b]) mem[paddr[2]][8*b +: 8] = pwdata[8*b +: 8];
                end else begin
                    prdata = mem[paddr[2]];
                end
            end
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            wcnt    = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic e, input logic t);
        exp_t x;
        x.rdata = d; x.slverr = e; x.timeout = t;
        sb_q.push_back(x);
    endtask

    task automatic start_req(input logic wr, input logic [2:0] a, input logic [31:0] d,
                             input logic [3:0] s, output int waited);
        int n = 0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_strb = s;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge pclk);
            n++;
        end
        waited = n;
        chk("req_ready_seen", 32'(n < 50), 32'd1);
        @(posedge pclk);
        @(negedge pclk);
        req_valid = 1'b0;
        chk("setup_psel",    32'(psel),    32'd1);
        chk("setup_penable", 32'(penable), 32'd0);
        chk("setup_paddr",   32'(paddr),   32'(a));
        chk("setup_pwrite",  32'(pwrite),  32'(wr));
        chk("setup_pstrb",   32'(pstrb),   wr ? 32'(s) : 32'd0);
        chk("pprot",         32'(pprot),   32'd0);
    endtask

    task automatic wait_rsp(input logic [2:0] a, input int exp_lat);
        int   lat = 0;
        exp_t x;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(negedge pclk);
            lat++;
            if (lat == 1) chk("access_penable", 32'(penable), 32'd1);
            if (psel === 1'b1) chk("paddr_hold", 32'(paddr), 32'(a));
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("done_psel",    32'(psel),    32'd0);
        chk("done_penable", 32'(penable), 32'd0);
        chk("done_pstrb",   32'(pstrb),   32'd0);
        chk("sb_nonempty",  32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            chk("rsp_rdata",   rsp_rdata,          x.rdata);
            chk("rsp_slverr",  32'(rsp_slverr),    32'(x.slverr));
            chk("rsp_timeout", 32'(rsp_timeout),   32'(x.timeout));
        end
    endtask

    task automatic finish_rsp(input int delay);
        logic [31:0] snap_d = rsp_rdata;
        logic        snap_e = rsp_slverr;
        for (int i = 0; i < delay; i++) begin
            @(negedge pclk);
            chk("hold_req_ready", 32'(req_ready),  32'd0);
            chk("hold_rsp_valid", 32'(rsp_valid),  32'd1);
            chk("hold_rsp_rdata", rsp_rdata,       snap_d);
            chk("hold_rsp_err",   32'(rsp_slverr), 32'(snap_e));
        end
        rsp_ready = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("rsp_cleared",    32'(rsp_valid), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int w;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0;   req_strb  = '0;   rsp_ready = 1'b0;
        #1 presetn = 1'b0;
        repeat (2) @(negedge pclk);
        chk("rst_req_ready",   32'(req_ready),   32'd0);
        chk("rst_psel",        32'(psel),        32'd0);
        chk("rst_penable",     32'(penable),     32'd0);
        chk("rst_pwrite",      32'(pwrite),      32'd0);
        chk("rst_paddr",       32'(paddr),       32'd0);
        chk("rst_pwdata",      pwdata,           32'd0);
        chk("rst_pstrb",       32'(pstrb),       32'd0);
        chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        chk("rst_rsp_rdata",   rsp_rdata,        32'd0);
        chk("rst_rsp_slverr",  32'(rsp_slverr),  32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        presetn = 1'b1;
        @(negedge pclk);

        // zero-wait write then readback
        push_exp(32'h0, 1'b0, 1'b0);
        start_req(1'b1, 3'h0, 32'hDEAD_BEEF, 4'hF, w); wait_rsp(3'h0, 2); finish_rsp(0);
        push_exp(32'hDEAD_BEEF, 1'b0, 1'b0);
        start_req(1'b0, 3'h0, 32'h0, 4'hF, w);          wait_rsp(3'h0, 2); finish_rsp(0);

        // read with three wait states
        push_exp(32'h0, 1'b0, 1'b0);
        start_req(1'b1, 3'h4, 32'hCAFE_BABE, 4'hF, w); wait_rsp(3'h4, 2); finish_rsp(0);
        wait_states = 3;
        push_exp(32'hCAFE_BABE, 1'b0, 1'b0);
        start_req(1'b0, 3'h4, 32'h0, 4'h0, w);          wait_rsp(3'h4, 5); finish_rsp(0);
        wait_states = 0;

        // slave error, with the next request pending through a slow response
        slv_err = 1'b1;
        push_exp(32'h0, 1'b1, 1'b0);
        start_req(1'b1, 3'h0, 32'h1122_3344, 4'h3, w); wait_rsp(3'h0, 2);
        slv_err = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'h0;
        push_exp(32'hDEAD_BEEF, 1'b0, 1'b0);
        finish_rsp(4);
        start_req(1'b0, 3'h0, 32'h0, 4'h0, w);
        chk("accept_after_handshake", 32'(w), 32'd0);
        wait_rsp(3'h0, 2); finish_rsp(0);

        // partial strobe write
        push_exp(32'h0, 1'b0, 1'b0);
        start_req(1'b1, 3'h4, 32'h0000_00AA, 4'h1, w); wait_rsp(3'h4, 2); finish_rsp(0);
        push_exp(32'hCAFE_BAAA, 1'b0, 1'b0);
        start_req(1'b0, 3'h4, 32'h0, 4'h0, w);          wait_rsp(3'h4, 2); finish_rsp(0);

        // reset asserted mid-ACCESS
        hang = 1'b1;
        start_req(1'b1, 3'h0, 32'hA5A5_A5A5, 4'hF, w);
        repeat (2) @(negedge pclk);
        chk("pre_rst_access", 32'(psel & penable), 32'd1);
        #2 presetn = 1'b0;
        #1;
        chk("arst_psel",      32'(psel),      32'd0);
        chk("arst_penable",   32'(penable),   32'd0);
        chk("arst_pwrite",    32'(pwrite),    32'd0);
        chk("arst_paddr",     32'(paddr),     32'd0);
        chk("arst_pstrb",     32'(pstrb),     32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        @(negedge pclk);
        presetn = 1'b1;
        hang    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("post_rst_psel",   32'(psel),      32'd0);
        end
        push_exp(32'h0, 1'b0, 1'b0);
        start_req(1'b1, 3'h0, 32'h1234_5678, 4'hF, w); wait_rsp(3'h0, 2); finish_rsp(0);
        push_exp(32'h1234_5678, 1'b0, 1'b0);
        start_req(1'b0, 3'h0, 32'h0, 4'h0, w);          wait_rsp(3'h0, 2); finish_rsp(0);

`ifdef APB4_REQ_MASTER_TIMEOUT_EN
        // 16 stalled ACCESS cycles terminate the transfer
        hang = 1'b1;
        push_exp(32'h0, 1'b1, 1'b1);
        start_req(1'b0, 3'h0, 32'h0, 4'h0, w);          wait_rsp(3'h0, 17); finish_rsp(0);
        hang = 1'b0;
        // pready on the 16th ACCESS cycle completes normally
        wait_states = 15;
        push_exp(32'h1234_5678, 1'b0, 1'b0);
        start_req(1'b0, 3'h0, 32'h0, 4'h0, w);          wait_rsp(3'h0, 17); finish_rsp(0);
        wait_states = 0;
`endif

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
